// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: drives IAD, buffers acknowledged {pc, instr} pairs and hands them to decode.
// Optional perf counters are enabled by defining IFETCH_PERF_EN.
module ifetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] IAD,
    input  logic [XLEN-1:0] IDT,
    input  logic            ACKI_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_full_stall
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_mem_r    [DEPTH];
    logic [XLEN-1:0] instr_mem_r [DEPTH];
    logic [AW-1:0]   rptr_r, wptr_r, rptr_n_s, wptr_n_s;
    logic [CW-1:0]   count_r, count_n_s, occ_s;
    logic [XLEN-1:0] fetch_pc_r, fetch_pc_n_s;
    logic [XLEN-1:0] id_pc_r, id_instr_r, head_pc_s, head_instr_s;
    logic            id_valid_r, pop_s, push_s, full_s;

    assign IAD      = fetch_pc_r;
    assign id_valid = id_valid_r;
    assign id_pc    = id_pc_r;
    assign id_instr = id_instr_r;

    // Handshake decode and next-state of pointers, occupancy and fetch address.
    always_comb begin
        pop_s        = id_valid_r & id_ready;
        full_s       = (count_r == CW'(DEPTH));
        push_s       = !ACKI_n & !redirect_valid & (!full_s | pop_s);
        occ_s        = count_r - CW'(pop_s);
        rptr_n_s     = rptr_r;
        wptr_n_s     = wptr_r;
        count_n_s    = count_r;
        fetch_pc_n_s = fetch_pc_r;
        if (redirect_valid) begin
            rptr_n_s     = {AW{1'b0}};
            wptr_n_s     = {AW{1'b0}};
            count_n_s    = {CW{1'b0}};
            fetch_pc_n_s = {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            rptr_n_s     = pop_s  ? rptr_r + AW'(1'b1) : rptr_r;
            wptr_n_s     = push_s ? wptr_r + AW'(1'b1) : wptr_r;
            count_n_s    = occ_s + CW'(push_s);
            fetch_pc_n_s = push_s ? fetch_pc_r + XLEN'(3'd4) : fetch_pc_r;
        end
    end

    // Next head entry; when the queue drains to empty the incoming word bypasses storage.
    always_comb begin
        head_pc_s    = id_pc_r;
        head_instr_s = id_instr_r;
        if (count_n_s == {CW{1'b0}}) begin
            head_pc_s    = id_pc_r;
            head_instr_s = id_instr_r;
        end else if (push_s && (occ_s == {CW{1'b0}})) begin
            head_pc_s    = fetch_pc_r;
            head_instr_s = IDT;
        end else begin
            head_pc_s    = pc_mem_r[rptr_n_s];
            head_instr_s = instr_mem_r[rptr_n_s];
        end
    end

    // Entry storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            pc_mem_r[wptr_r]    <= fetch_pc_r;
            instr_mem_r[wptr_r] <= IDT;
        end
    end

    // Control and head registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            rptr_r     <= {AW{1'b0}};
            wptr_r     <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            id_valid_r <= 1'b0;
            id_pc_r    <= {XLEN{1'b0}};
            id_instr_r <= {XLEN{1'b0}};
        end else begin
            fetch_pc_r <= fetch_pc_n_s;
            rptr_r     <= rptr_n_s;
            wptr_r     <= wptr_n_s;
            count_r    <= count_n_s;
            id_valid_r <= (count_n_s != {CW{1'b0}});
            id_pc_r    <= head_pc_s;
            id_instr_r <= head_instr_s;
        end
    end

`ifdef IFETCH_PERF_EN
    logic stall_s;
    assign stall_s = !ACKI_n & !redirect_valid & full_s & !pop_s;

    // Saturating event counters for pushes and full-queue ack rejections.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched    <= 32'd0;
            perf_full_stall <= 32'd0;
        end else begin
            if (push_s && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end else begin
                perf_fetched <= perf_fetched;
            end
            if (stall_s && (perf_full_stall != 32'hFFFF_FFFF)) begin
                perf_full_stall <= perf_full_stall + 32'd1;
            end else begin
                perf_full_stall <= perf_full_stall;
            end
        end
    end
`endif

endmodule
